cross_bar_mux_arbiter: RTL and testbench

N-to-1 packet merger for the egress side of the MxN crossbar. It is the counterpart of the per-input demux stage.
- Collects AXI-Stream packets from CHANNEL_NO input channels.
- Grants one channel at a time with packet-level round-robin arbitration and holds the grant until that packet's tlast beat is accepted.
- Forwards beats through a registered skid stage to a single output port. The source channel index travels with each beat on m_axis_tid.

---
 rtl/crossbar_pkg.sv | 30 +++
 rtl/axis_skid_buffer.sv | 81 ++++++++
 rtl/cross_bar_mux_arbiter.sv | 90 +++++++++
 tb/tb_cross_bar_mux_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar stages.
// Round-robin pick is kept here so demux and mux agree on priority.
package crossbar_pkg;

  localparam int RR_MAX = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  // First requester strictly after 'last', wrapping modulo n.
  function automatic int rr_next(
    input logic [RR_MAX-1:0] req,
    input int                last,
    input int                n
  );
    logic [RR_MAX-1:0] sh;
    int                idx;
    rr_next = last;
    for (int i = RR_MAX; i >= 1; i--) begin
      if (i <= n) begin
        idx = (last + i) % n;
        sh  = req >> idx;
        if (sh[0]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice.
// Ready depends only on occupancy, never on downstream ready.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  input  logic [USER_WIDTH-1:0] s_user_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [USER_WIDTH-1:0] m_user_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);

  localparam int W = DATA_WIDTH + 1 + USER_WIDTH;

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] in_ent;
  logic         push, pop;

  assign in_ent    = {s_data_i, s_last_i, s_user_i};
  assign s_ready_o = (cnt_q != 2'd2);
  assign m_valid_o = (cnt_q != 2'd0);
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  assign {m_data_o, m_last_o, m_user_o} = e0_q;

  // e0 is always the head; e1 only holds the overflow beat.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_d  = in_ent;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          e0_d = in_ent;
        end else if (push) begin
          e1_d  = in_ent;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          e0_d  = e1_q;
          cnt_d = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cross_bar_mux_arbiter.sv
// N-to-1 egress packet merger with packet-level round-robin.
// Grant is held until the granted packet's tlast is accepted.
module cross_bar_mux_arbiter
  import crossbar_pkg::*;
#(
  parameter int MSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata [CHANNEL_NO],
  input  logic [CHANNEL_NO-1:0] s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0] s_axis_tlast,
  output logic [CHANNEL_NO-1:0] s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [MSEL_WIDTH-1:0] m_axis_tid,
  input  logic                  m_axis_tready
);

  arb_state_t            state_q, state_d;
  logic [MSEL_WIDTH-1:0] grant_q, grant_d;
  logic [MSEL_WIDTH-1:0] last_q, last_d;
  logic [MSEL_WIDTH-1:0] pick;
  logic                  skid_rdy;
  logic                  in_valid;
  logic                  beat;

  assign pick = MSEL_WIDTH'(rr_next(RR_MAX'(s_axis_tvalid),
                                    int'(last_q), CHANNEL_NO));

  assign in_valid = (state_q == ACTIVE) & s_axis_tvalid[grant_q];
  assign beat     = in_valid & skid_rdy;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ACTIVE) s_axis_tready[grant_q] = skid_rdy;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          state_d = ACTIVE;
          grant_d = pick;
          last_d  = pick;
        end
      end
      ACTIVE: begin
        if (beat && s_axis_tlast[grant_q]) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= MSEL_WIDTH'(CHANNEL_NO - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (MSEL_WIDTH)
  ) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_data_i  (s_axis_tdata[grant_q]),
    .s_last_i  (s_axis_tlast[grant_q]),
    .s_user_i  (grant_q),
    .s_valid_i (in_valid),
    .s_ready_o (skid_rdy),
    .m_data_o  (m_axis_tdata),
    .m_last_o  (m_axis_tlast),
    .m_user_o  (m_axis_tid),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

endmodule

// File: tb/tb_cross_bar_mux_arbiter.sv
// Bench for cross_bar_mux_arbiter: randomized sources,
// per-channel packet FIFOs as the reference model.
module tb_cross_bar_mux_arbiter;

  localparam int MSW = 2;
  localparam int CH  = 4;
  localparam int DW  = 32;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [DW-1:0]   s_axis_tdata [CH];
  logic [CH-1:0]   s_axis_tvalid;
  logic [CH-1:0]   s_axis_tlast;
  logic [CH-1:0]   s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [MSW-1:0]  m_axis_tid;
  logic            m_axis_tready;

  always #5 aclk = ~aclk;

  cross_bar_mux_arbiter #(
    .MSEL_WIDTH (MSW),
    .CHANNEL_NO (CH),
    .DATA_WIDTH (DW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready)
  );

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct {
    logic [DW-1:0]  d;
    logic           l;
    logic [MSW-1:0] id;
    int             cyc;
  } obs_t;

  beat_t src_q [CH][$];
  beat_t exp_q [CH][$];
  obs_t  obs [$];

  logic [CH-1:0]  hs;
  logic [CH-1:0]  mid_pkt;
  int             sent [CH];
  int             pause [CH];
  int             gap_beat [CH];
  int             gap_len [CH];
  int             vprob, rdy_mode, rdy_phase, cyc, inflight;
  int             full_seen, stab_viol, rdy_viol;
  logic           prev_stall;
  logic [DW-1:0]  pd;
  logic           pl;
  logic [MSW-1:0] pid;
  int             passed, total;

  function automatic beat_t pop_exp(input logic [MSW-1:0] id);
    beat_t b;
    b.d = 'x;
    b.l = 1'bx;
    if (exp_q[id].size() > 0) b = exp_q[id].pop_front();
    return b;
  endfunction

  function automatic int exp_left();
    int n = 0;
    for (int c = 0; c < CH; c++) n += exp_q[c].size();
    return n;
  endfunction

  task automatic load_pkt(input int c, input int len,
                          input logic [DW-1:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = rnd ? DW'($urandom) : base + DW'(i);
      b.l = (i == len - 1);
      src_q[c].push_back(b);
      exp_q[c].push_back(b);
    end
  endtask

  task automatic clear_bench();
    for (int c = 0; c < CH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
      pause[c] = 0;
      gap_beat[c] = -1;
    end
    obs.delete();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    hs = '0;
    mid_pkt = '0;
    inflight = 0;
    prev_stall = 1'b0;
    full_seen = 0;
    stab_viol = 0;
    rdy_viol = 0;
  endtask

  // One clock: retire handshakes, drive sources, sample at negedge.
  task automatic run_cycles(input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (hs[c]) begin
          b = src_q[c].pop_front();
          sent[c]++;
          s_axis_tvalid[c] = 1'b0;
          if (sent[c] == gap_beat[c]) pause[c] = gap_len[c];
        end
        if (!s_axis_tvalid[c]) begin
          if (pause[c] > 0) pause[c]--;
          else if (src_q[c].size() > 0 &&
                   int'($urandom_range(99)) < vprob) begin
            s_axis_tvalid[c] = 1'b1;
            s_axis_tdata[c]  = src_q[c][0].d;
            s_axis_tlast[c]  = src_q[c][0].l;
          end
        end
      end
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (rdy_phase % 3 == 0);
        default: m_axis_tready = (int'($urandom_range(99)) < 70);
      endcase
      rdy_phase++;
      @(negedge aclk);
      hs = s_axis_tvalid & s_axis_tready;
      if ($countones(s_axis_tready) > 1) rdy_viol++;
      if (s_axis_tready != '0 && inflight >= 2) rdy_viol++;
      for (int c = 0; c < CH; c++) begin
        if (mid_pkt[c] && inflight < 2 && !s_axis_tready[c]) rdy_viol++;
        if (hs[c]) mid_pkt[c] = !s_axis_tlast[c];
      end
      if (inflight == 2) full_seen++;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== pd ||
          m_axis_tlast !== pl || m_axis_tid !== pid)) stab_viol++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd  = m_axis_tdata;
      pl  = m_axis_tlast;
      pid = m_axis_tid;
      if (m_axis_tvalid && m_axis_tready)
        obs.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tid, cyc});
      inflight += (hs != '0) ? 1 : 0;
      inflight -= (m_axis_tvalid && m_axis_tready) ? 1 : 0;
      cyc++;
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic run_drain(input int limit, output bit ok);
    int left;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      run_cycles(1);
      left = 0;
      for (int c = 0; c < CH; c++) left += src_q[c].size();
      if (left == 0 && inflight == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axis_tvalid = CH'($urandom);
    s_axis_tlast  = CH'($urandom);
    for (int c = 0; c < CH; c++) s_axis_tdata[c] = $urandom;
    m_axis_tready = 1'b1;
    #23;
    total++;
    if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0) begin
      $display("FAIL reset_hs: tready=%b tvalid=%b want 0000/0",
               s_axis_tready, m_axis_tvalid);
    end else passed++;
    total++;
    if (m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 ||
        m_axis_tid !== '0) begin
      $display("FAIL reset_out: data=%h last=%b tid=%0d want 0/0/0",
               m_axis_tdata, m_axis_tlast, m_axis_tid);
    end else passed++;
    clear_bench();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    run_cycles(6);
    total++;
    if (obs.size() != 0 || m_axis_tvalid !== 1'b0 ||
        s_axis_tready !== '0) begin
      $display("FAIL reset_idle: beats=%0d tvalid=%b want 0/0",
               obs.size(), m_axis_tvalid);
    end else passed++;
  endtask

  task automatic test_contention();
    bit             ok;
    beat_t          e;
    int             p, lc;
    logic           inpk;
    logic [MSW-1:0] ctid;
    clear_bench();
    vprob = 100;
    rdy_mode = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++)
        load_pkt(c, 2, DW'(32'hC000 + c * 16 + r * 4), 1'b0);
    run_drain(200, ok);
    total++;
    if (!ok) $display("FAIL cont_drain: timed out, left=%0d want 0", exp_left());
    else passed++;
    p = 0;
    lc = -10;
    inpk = 1'b0;
    ctid = '0;
    foreach (obs[i]) begin
      e = pop_exp(obs[i].id);
      total++;
      if (obs[i].d !== e.d || obs[i].l !== e.l) begin
        $display("FAIL cont_beat: ch%0d got %h/%b want %h/%b",
                 obs[i].id, obs[i].d, obs[i].l, e.d, e.l);
      end else passed++;
      if (!inpk) begin
        total++;
        if (obs[i].id !== MSW'(p % CH)) begin
          $display("FAIL cont_order: packet %0d tid=%0d want %0d",
                   p, obs[i].id, p % CH);
        end else passed++;
        if (p > 0) begin
          total++;
          if (obs[i].cyc != lc + 2) begin
            $display("FAIL cont_bubble: gap=%0d want 2", obs[i].cyc - lc);
          end else passed++;
        end
        ctid = obs[i].id;
        p++;
      end else begin
        total++;
        if (obs[i].id !== ctid || obs[i].cyc != lc + 1) begin
          $display("FAIL cont_interleave: tid=%0d gap=%0d want %0d/1",
                   obs[i].id, obs[i].cyc - lc, ctid);
        end else passed++;
      end
      inpk = !obs[i].l;
      lc = obs[i].cyc;
    end
    total++;
    if (p != 8 || exp_left() != 0) begin
      $display("FAIL cont_count: packets=%0d left=%0d want 8/0", p, exp_left());
    end else passed++;
  endtask

  task automatic test_single();
    int    c0;
    beat_t e;
    clear_bench();
    vprob = 100;
    rdy_mode = 0;
    load_pkt(2, 4, DW'(32'hA0), 1'b0);
    c0 = cyc;
    run_cycles(9);
    total++;
    if (obs.size() != 4) begin
      $display("FAIL single_count: beats=%0d want 4", obs.size());
    end else passed++;
    foreach (obs[i]) begin
      e = pop_exp(2'd2);
      total++;
      if (obs[i].d !== e.d || obs[i].l !== e.l || obs[i].id !== 2'd2 ||
          obs[i].cyc != c0 + 2 + i) begin
        $display("FAIL single_beat%0d: %h/%b/tid%0d/cyc%0d want %h/%b/tid2/cyc%0d",
                 i, obs[i].d, obs[i].l, obs[i].id, obs[i].cyc - c0,
                 e.d, e.l, 2 + i);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit    ok;
    beat_t e;
    clear_bench();
    vprob = 100;
    rdy_mode = 1;
    rdy_phase = 0;
    load_pkt(1, 8, '0, 1'b1);
    run_drain(200, ok);
    total++;
    if (!ok || obs.size() != 8) begin
      $display("FAIL bp_count: done=%0b beats=%0d want 1/8", ok, obs.size());
    end else passed++;
    foreach (obs[i]) begin
      e = pop_exp(obs[i].id);
      total++;
      if (obs[i].d !== e.d || obs[i].l !== e.l || obs[i].id !== 2'd1) begin
        $display("FAIL bp_beat%0d: %h/%b/tid%0d want %h/%b/tid1",
                 i, obs[i].d, obs[i].l, obs[i].id, e.d, e.l);
      end else passed++;
    end
    total++;
    if (stab_viol != 0) $display("FAIL bp_stable: violations=%0d want 0", stab_viol);
    else passed++;
    total++;
    if (rdy_viol != 0 || full_seen == 0) begin
      $display("FAIL bp_ready: violations=%0d full_cycles=%0d want 0/>0",
               rdy_viol, full_seen);
    end else passed++;
  endtask

  task automatic test_gap();
    bit    ok;
    beat_t e;
    int    last3, first0, maxgap;
    clear_bench();
    vprob = 100;
    rdy_mode = 0;
    gap_beat[3] = sent[3] + 2;
    gap_len[3]  = 5;
    load_pkt(3, 6, DW'(32'h300), 1'b0);
    run_cycles(3);
    load_pkt(0, 4, DW'(32'h400), 1'b0);
    run_drain(200, ok);
    total++;
    if (!ok || obs.size() != 10) begin
      $display("FAIL gap_count: done=%0b beats=%0d want 1/10", ok, obs.size());
    end else passed++;
    last3 = -1;
    first0 = 1000;
    maxgap = 0;
    foreach (obs[i]) begin
      e = pop_exp(obs[i].id);
      total++;
      if (obs[i].d !== e.d || obs[i].l !== e.l) begin
        $display("FAIL gap_beat: ch%0d got %h/%b want %h/%b",
                 obs[i].id, obs[i].d, obs[i].l, e.d, e.l);
      end else passed++;
      if (obs[i].id == 2'd3) last3 = i;
      if (obs[i].id == 2'd0 && first0 == 1000) first0 = i;
      if (i > 0 && obs[i].id == 2'd3 && obs[i].cyc - obs[i-1].cyc > maxgap)
        maxgap = obs[i].cyc - obs[i-1].cyc;
    end
    total++;
    if (last3 >= first0 || maxgap != 6) begin
      $display("FAIL gap_hold: last_ch3=%0d first_ch0=%0d gap=%0d want <,6",
               last3, first0, maxgap);
    end else passed++;
    total++;
    if (rdy_viol != 0) $display("FAIL gap_ready: violations=%0d want 0", rdy_viol);
    else passed++;
    gap_beat[3] = -1;
  endtask

  task automatic test_async_reset();
    bit    ok;
    beat_t e;
    clear_bench();
    vprob = 100;
    rdy_mode = 0;
    sent[0] = 0;
    load_pkt(0, 8, DW'(32'h500), 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      run_cycles(1);
      ok = (sent[0] >= 3);
    end
    total++;
    if (!ok) $display("FAIL arst_wait: sent=%0d want 3", sent[0]);
    else passed++;
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 ||
        m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || m_axis_tid !== '0) begin
      $display("FAIL arst_clear: tvalid=%b tready=%b data=%h want 0/0000/0",
               m_axis_tvalid, s_axis_tready, m_axis_tdata);
    end else passed++;
    #2;
    aresetn = 1'b1;
    clear_bench();
    @(posedge aclk);
    #1;
    load_pkt(1, 4, DW'(32'h610), 1'b0);
    run_drain(100, ok);
    total++;
    if (!ok || obs.size() != 4) begin
      $display("FAIL arst_count: done=%0b beats=%0d want 1/4", ok, obs.size());
    end else passed++;
    foreach (obs[i]) begin
      e = pop_exp(obs[i].id);
      total++;
      if (obs[i].d !== e.d || obs[i].l !== e.l || obs[i].id !== 2'd1) begin
        $display("FAIL arst_beat%0d: %h/%b/tid%0d want %h/%b/tid1",
                 i, obs[i].d, obs[i].l, obs[i].id, e.d, e.l);
      end else passed++;
    end
  endtask

  task automatic test_random();
    bit             ok;
    beat_t          e;
    logic           inpk;
    logic [MSW-1:0] ctid;
    clear_bench();
    vprob = 60;
    rdy_mode = 2;
    for (int p = 0; p < 16; p++)
      load_pkt(int'($urandom_range(CH - 1)), int'($urandom_range(5, 1)), '0, 1'b1);
    run_drain(3000, ok);
    total++;
    if (!ok) $display("FAIL rand_drain: timed out, left=%0d want 0", exp_left());
    else passed++;
    inpk = 1'b0;
    ctid = '0;
    foreach (obs[i]) begin
      e = pop_exp(obs[i].id);
      total++;
      if (obs[i].d !== e.d || obs[i].l !== e.l || (inpk && obs[i].id !== ctid)) begin
        $display("FAIL rand_beat%0d: ch%0d %h/%b want ch%0d %h/%b",
                 i, obs[i].id, obs[i].d, obs[i].l, inpk ? ctid : obs[i].id, e.d, e.l);
      end else passed++;
      inpk = !obs[i].l;
      ctid = obs[i].id;
    end
    total++;
    if (exp_left() != 0 || stab_viol != 0 || rdy_viol != 0) begin
      $display("FAIL rand_rules: left=%0d stab=%0d ready=%0d want 0/0/0",
               exp_left(), stab_viol, rdy_viol);
    end else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    cyc = 0;
    rdy_phase = 0;
    vprob = 100;
    rdy_mode = 0;
    m_axis_tready = 1'b0;
    for (int c = 0; c < CH; c++) begin
      s_axis_tdata[c] = '0;
      sent[c] = 0;
      gap_len[c] = 0;
    end
    clear_bench();
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_gap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
